ysyx_22040237_mc_ctrl: RTL and testbench
========================================

# ysyx_22040237_mc_ctrl

Multi-cycle core controller that succeeds the single-cycle top-level sequencing. It owns the PC register and sequences each instruction through fetch, execute, memory and writeback with valid/ready handshakes to instruction and data memory of arbitrary latency. It gates register-file writeback, counts retired instructions and halts on ebreak, illegal instruction, bus error, misaligned jump or bus timeout. It sits between the memory interfaces and the existing IDU/EXU/LSU/WBU datapath, and replaces the free-running PC register.

## Interface
- XLEN, 64, datapath/PC width.
- INST_W, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC loaded at reset (truncated to XLEN).
- TIMEOUT, 255, maximum wait cycles for a memory response; valid range 1..2^16-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  fetch request accepted.
- imem_addr  out  XLEN  fetch address; equals pc_o.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  INST_W  fetched instruction.
- imem_rsp_err  in  1  fetch bus error; qualified by imem_rsp_valid.
- inst_o  out  INST_W  latched instruction to the IDU.
- pc_o  out  XLEN  current instruction PC.
- dec_is_mem_i  in  1  decoded load/store.
- dec_rd_wr_en_i  in  1  decoded rd write enable.
- invalid_inst_i  in  1  IDU illegal instruction.
- ebreak_i  in  1  decoded ebreak.
- exu_stall_i  in  1  EXU busy (multi-cycle op).
- jump_flag_i  in  1  taken branch/jump.
- jump_addr_i  in  XLEN  jump target.
- dmem_req_valid  out  1  data request.
- dmem_req_ready  in  1  data request accepted.
- dmem_rsp_valid  in  1  data response/ack.
- dmem_rsp_err  in  1  data bus error; qualified by dmem_rsp_valid.
- rf_wr_en_o  out  1  register-file write strobe.
- retire_o  out  1  one-cycle pulse per retired instruction.
- retire_cnt_o  out  64  retired-instruction counter.
- halt_o  out  1  sticky halt.
- cause_o  out  3  halt cause: 0 ebreak, 1 illegal, 2 fetch error, 3 data error, 4 timeout, 5 misaligned jump.
- state_o  out  3  current FSM state (debug).

## Operation
- FSM states: IDLE, IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT.
- IDLE: entered on reset. Advances to IF_REQ unconditionally on the next cycle.
- IF_REQ: imem_req_valid=1 and imem_addr stable. On valid&ready, go to IF_WAIT.
- IF_WAIT: on rsp_valid, go to HALT with cause 2 if err. Otherwise capture inst_o and go to EX.
- EX: ebreak_i or invalid_inst_i goes to HALT (cause 0 / 1), with ebreak taking priority. Otherwise hold while exu_stall_i. Otherwise go to MEM_REQ if dec_is_mem_i, else WB.
- MEM_REQ / MEM_WAIT mirror the fetch handshake on dmem_*. An error goes to HALT with cause 3. Otherwise go to WB.
- WB: rf_wr_en_o=dec_rd_wr_en_i and retire_o=1 for exactly this cycle; retire_cnt_o increments.
  - Next PC is jump_addr_i if jump_flag_i, else pc_o+4, modulo 2^XLEN.
  - If jump_flag_i and jump_addr_i[1:0]!=0: no retire, no rf write, go to HALT with cause 5.
  - Otherwise go to IF_REQ.
- Timeout: a wait counter clears on entry to IF_WAIT/MEM_WAIT and increments each cycle without a response. If it reaches TIMEOUT, go to HALT with cause 4.
- HALT: all request valids 0, halt_o=1, cause_o held. The FSM leaves HALT only on reset.
- Responses are only accepted in IF_WAIT/MEM_WAIT. A response arriving in any other state is ignored.

## Timing
- Reset values: pc_o=RESET_PC; inst_o=0; all valids, rf_wr_en_o, retire_o and halt_o = 0; cause_o=0; retire_cnt_o=0; state IDLE.
- Reset asserted mid-transaction: outputs take reset values at the next edge. Outstanding memory responses are dropped.
- With zero-wait memory (ready high, response the cycle after accept), a non-memory instruction takes 4 cycles: IF_REQ, IF_WAIT, EX, WB. A memory instruction takes 6.
- First fetch request is asserted 1 cycle after reset release.
- pc_o updates at the WB→IF_REQ edge. inst_o updates only at the IF_WAIT capture edge.
- Valid stays asserted, with address stable, until ready. Dropping a request before acceptance is forbidden.

## Structure
- Shared package ysyx_22040237_mc_pkg holds:
  - the FSM state enum (3-bit encoding);
  - cause codes;
  - default RESET_PC;
  - the INST_W and XLEN defaults shared with the IDU/EXU.
- One sub-module, ysyx_22040237_bus_timer: clear/enable inputs, TIMEOUT parameter, expired output. It is instantiated once and shared by both wait states.

## Test plan
- Reset release with zero-wait imem, sequence of 3 addi → fetches at 0x8000_0000, 0x8000_0004, 0x8000_0008; retire every 4 cycles; retire_cnt_o=3.
- jal with target 0x8000_0100 in WB → next imem_addr 0x8000_0100. Target 0x8000_0102 → halt_o=1, cause_o=5, no retire, rf_wr_en_o stays 0.
- Load with dmem ready delayed 3 cycles and response delayed 5 → dmem_req_valid held with no drop; retire after response; 6+8 total cycles.
- imem never responds with TIMEOUT=16 → halt 16 cycles after entering IF_WAIT with cause_o=4. Reset then restarts fetch at RESET_PC with retire_cnt_o=0.
- exu_stall_i high for 10 cycles in EX → FSM holds EX, no retire. Illegal instruction → cause_o=1. Data rsp_err → cause_o=3.
- Reset asserted while in MEM_WAIT → dmem_req_valid=0 and state IDLE after one edge. A late dmem_rsp_valid is ignored.

Source files
------------

// File: rtl/ysyx_22040237_mc_pkg.sv
// Shared types and defaults for the multi-cycle core controller.
// The IDU/EXU reuse the XLEN/INST_W defaults.
package ysyx_22040237_mc_pkg;
  localparam int          XLEN_DEF     = 64;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } mc_state_e;

  typedef enum logic [2:0] {
    C_EBREAK    = 3'd0,
    C_ILLEGAL   = 3'd1,
    C_FETCH_ERR = 3'd2,
    C_DATA_ERR  = 3'd3,
    C_TIMEOUT   = 3'd4,
    C_MISALIGN  = 3'd5
  } mc_cause_e;
endpackage

// File: rtl/ysyx_22040237_bus_timer.sv
// Response wait counter shared by the fetch and data wait states.
// expired fires in the cycle whose increment would reach TIMEOUT.
module ysyx_22040237_bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (en)     cnt <= cnt + 16'd1;
  end

  assign expired = en && (cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/ysyx_22040237_mc_ctrl.sv
// Multi-cycle sequencer: owns the PC, handshakes with imem/dmem,
// gates writeback, counts retirements and halts on faults.
module ysyx_22040237_mc_ctrl
  import ysyx_22040237_mc_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEF,
  parameter int          INST_W   = INST_W_DEF,
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   pc_o,
  input  logic              dec_is_mem_i,
  input  logic              dec_rd_wr_en_i,
  input  logic              invalid_inst_i,
  input  logic              ebreak_i,
  input  logic              exu_stall_i,
  input  logic              jump_flag_i,
  input  logic [XLEN-1:0]   jump_addr_i,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  input  logic              dmem_rsp_valid,
  input  logic              dmem_rsp_err,
  output logic              rf_wr_en_o,
  output logic              retire_o,
  output logic [63:0]       retire_cnt_o,
  output logic              halt_o,
  output logic [2:0]        cause_o,
  output logic [2:0]        state_o
);
  mc_state_e         state, state_nxt;
  mc_cause_e         cause_q, cause_nxt;
  logic [XLEN-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic [63:0]       retire_cnt_q;
  logic              waiting, rsp_valid, expired, misalign, wb_commit;

  assign waiting   = (state == S_IF_WAIT) || (state == S_MEM_WAIT);
  assign rsp_valid = (state == S_IF_WAIT) ? imem_rsp_valid : dmem_rsp_valid;
  assign misalign  = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
  assign wb_commit = (state == S_WB) && !misalign;

  ysyx_22040237_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting),
    .en      (waiting && !rsp_valid),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    case (state)
      S_IDLE:   state_nxt = S_IF_REQ;
      S_IF_REQ: if (imem_req_ready) state_nxt = S_IF_WAIT;
      S_IF_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_nxt = S_HALT;
            cause_nxt = C_FETCH_ERR;
          end else begin
            state_nxt = S_EX;
          end
        end else if (expired) begin
          state_nxt = S_HALT;
          cause_nxt = C_TIMEOUT;
        end
      end
      S_EX: begin
        if (ebreak_i) begin
          state_nxt = S_HALT;
          cause_nxt = C_EBREAK;
        end else if (invalid_inst_i) begin
          state_nxt = S_HALT;
          cause_nxt = C_ILLEGAL;
        end else if (!exu_stall_i) begin
          state_nxt = dec_is_mem_i ? S_MEM_REQ : S_WB;
        end
      end
      S_MEM_REQ: if (dmem_req_ready) state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          if (dmem_rsp_err) begin
            state_nxt = S_HALT;
            cause_nxt = C_DATA_ERR;
          end else begin
            state_nxt = S_WB;
          end
        end else if (expired) begin
          state_nxt = S_HALT;
          cause_nxt = C_TIMEOUT;
        end
      end
      S_WB: begin
        if (misalign) begin
          state_nxt = S_HALT;
          cause_nxt = C_MISALIGN;
        end else begin
          state_nxt = S_IF_REQ;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cause_q      <= C_EBREAK;
      pc_q         <= RESET_PC[XLEN-1:0];
      inst_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == S_IF_WAIT && imem_rsp_valid && !imem_rsp_err)
        inst_q <= imem_rsp_data;
      // A misaligned jump halts without committing, so the PC stays on it
      if (wb_commit) begin
        pc_q         <= jump_flag_i ? jump_addr_i : pc_q + XLEN'(4);
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
    end
  end

  assign imem_req_valid = (state == S_IF_REQ);
  assign imem_addr      = pc_q;
  assign pc_o           = pc_q;
  assign inst_o         = inst_q;
  assign dmem_req_valid = (state == S_MEM_REQ);
  assign rf_wr_en_o     = wb_commit && dec_rd_wr_en_i;
  assign retire_o       = wb_commit;
  assign retire_cnt_o   = retire_cnt_q;
  assign halt_o         = (state == S_HALT);
  assign cause_o        = cause_q;
  assign state_o        = state;
endmodule

// File: tb/tb_ysyx_22040237_mc_ctrl.sv
// Directed bench: cycle-by-cycle vector table for the main instruction flow,
// plus hand-written sequences for stalls, faults, timeout and mid-flight reset.
module tb_ysyx_22040237_mc_ctrl;
  import ysyx_22040237_mc_pkg::*;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
  logic [63:0] imem_addr, pc_o, jump_addr_i;
  logic [31:0] imem_rsp_data, inst_o;
  logic        dec_is_mem_i, dec_rd_wr_en_i, invalid_inst_i, ebreak_i;
  logic        exu_stall_i, jump_flag_i;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid, dmem_rsp_err;
  logic        rf_wr_en_o, retire_o, halt_o;
  logic [63:0] retire_cnt_o;
  logic [2:0]  cause_o, state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction word derived from the fetch address so each fetch is distinct
  assign imem_rsp_data = imem_addr[31:0] ^ 32'h0000_0013;

  ysyx_22040237_mc_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_o(inst_o), .pc_o(pc_o),
    .dec_is_mem_i(dec_is_mem_i), .dec_rd_wr_en_i(dec_rd_wr_en_i),
    .invalid_inst_i(invalid_inst_i), .ebreak_i(ebreak_i),
    .exu_stall_i(exu_stall_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_err(dmem_rsp_err),
    .rf_wr_en_o(rf_wr_en_o), .retire_o(retire_o), .retire_cnt_o(retire_cnt_o),
    .halt_o(halt_o), .cause_o(cause_o), .state_o(state_o)
  );

  typedef struct {
    mc_state_e   st;
    logic [63:0] pc;
    logic        ret;
    logic [63:0] cnt;
    logic        jf;
    logic [63:0] ja;
    logic        mem;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input mc_state_e st, input logic [63:0] pc, input logic ret,
                              input logic [63:0] cnt, input logic jf, input logic [63:0] ja,
                              input logic mem);
    vec_t v;
    v.st = st; v.pc = pc; v.ret = ret; v.cnt = cnt; v.jf = jf; v.ja = ja; v.mem = mem;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Hold reset two edges with benign defaults, check reset values, then release.
  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b0;
    dec_is_mem_i = 1'b0; dec_rd_wr_en_i = 1'b1; invalid_inst_i = 1'b0; ebreak_i = 1'b0;
    exu_stall_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 64'h0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_err = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst state", 64'(state_o), 64'(S_IDLE));
    chk("rst pc", pc_o, B);
    chk("rst inst", 64'(inst_o), 64'h0);
    chk("rst ivalid", 64'(imem_req_valid), 64'h0);
    chk("rst dvalid", 64'(dmem_req_valid), 64'h0);
    chk("rst retire", 64'(retire_o), 64'h0);
    chk("rst rfwr", 64'(rf_wr_en_o), 64'h0);
    chk("rst halt", 64'(halt_o), 64'h0);
    chk("rst cause", 64'(cause_o), 64'h0);
    chk("rst cnt", retire_cnt_o, 64'h0);
    rst = 1'b1;
  endtask

  task automatic wait_state(input mc_state_e s, input int lim, input string nm);
    int n;
    n = 0;
    while (state_o !== s && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, 64'(state_o), 64'(s));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc, nv, rc, nex, nret;

    // 3 addi, jal to B+0x100, zero-wait load, then misaligned jal
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(S_IF_REQ,  B + 64'(4*i), 1'b0, 64'(i), 1'b0, 64'h0, 1'b0));
      tbl.push_back(mk(S_IF_WAIT, B + 64'(4*i), 1'b0, 64'(i), 1'b0, 64'h0, 1'b0));
      tbl.push_back(mk(S_EX,      B + 64'(4*i), 1'b0, 64'(i), 1'b0, 64'h0, 1'b0));
      tbl.push_back(mk(S_WB,      B + 64'(4*i), 1'b1, 64'(i), 1'b0, 64'h0, 1'b0));
    end
    tbl.push_back(mk(S_IF_REQ,   B + 64'hC,   1'b0, 64'd3, 1'b1, B + 64'h100, 1'b0));
    tbl.push_back(mk(S_IF_WAIT,  B + 64'hC,   1'b0, 64'd3, 1'b1, B + 64'h100, 1'b0));
    tbl.push_back(mk(S_EX,       B + 64'hC,   1'b0, 64'd3, 1'b1, B + 64'h100, 1'b0));
    tbl.push_back(mk(S_WB,       B + 64'hC,   1'b1, 64'd3, 1'b1, B + 64'h100, 1'b0));
    tbl.push_back(mk(S_IF_REQ,   B + 64'h100, 1'b0, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_IF_WAIT,  B + 64'h100, 1'b0, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_EX,       B + 64'h100, 1'b0, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_MEM_REQ,  B + 64'h100, 1'b0, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_MEM_WAIT, B + 64'h100, 1'b0, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_WB,       B + 64'h100, 1'b1, 64'd4, 1'b0, 64'h0, 1'b1));
    tbl.push_back(mk(S_IF_REQ,   B + 64'h104, 1'b0, 64'd5, 1'b1, B + 64'h102, 1'b0));
    tbl.push_back(mk(S_IF_WAIT,  B + 64'h104, 1'b0, 64'd5, 1'b1, B + 64'h102, 1'b0));
    tbl.push_back(mk(S_EX,       B + 64'h104, 1'b0, 64'd5, 1'b1, B + 64'h102, 1'b0));
    tbl.push_back(mk(S_WB,       B + 64'h104, 1'b0, 64'd5, 1'b1, B + 64'h102, 1'b0));
    tbl.push_back(mk(S_HALT,     B + 64'h104, 1'b0, 64'd5, 1'b1, B + 64'h102, 1'b0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      jump_flag_i = tbl[i].jf; jump_addr_i = tbl[i].ja; dec_is_mem_i = tbl[i].mem;
      #1;
      chk($sformatf("r%0d state", i), 64'(state_o), 64'(tbl[i].st));
      chk($sformatf("r%0d addr", i), imem_addr, tbl[i].pc);
      chk($sformatf("r%0d ivalid", i), 64'(imem_req_valid), 64'(tbl[i].st == S_IF_REQ));
      chk($sformatf("r%0d dvalid", i), 64'(dmem_req_valid), 64'(tbl[i].st == S_MEM_REQ));
      chk($sformatf("r%0d retire", i), 64'(retire_o), 64'(tbl[i].ret));
      chk($sformatf("r%0d rfwr", i), 64'(rf_wr_en_o), 64'(tbl[i].ret));
      chk($sformatf("r%0d cnt", i), retire_cnt_o, tbl[i].cnt);
      if (tbl[i].st == S_EX)
        chk($sformatf("r%0d inst", i), 64'(inst_o), 64'(tbl[i].pc[31:0] ^ 32'h13));
    end
    chk("misalign halt", 64'(halt_o), 64'h1);
    chk("misalign cause", 64'(cause_o), 64'(C_MISALIGN));

    // Load with dmem ready 3 cycles late and response 5 cycles late
    do_reset();
    dec_is_mem_i = 1'b1; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    nv = 0; rc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      dmem_req_ready = (c == 7);
      dmem_rsp_valid = (c == 5) || (c == 13);
      #1;
      if (dmem_req_valid) nv++;
      if (retire_o && rc == 0) rc = c;
    end
    chk("load dvalid cycles", 64'(nv), 64'd4);
    chk("load retire cycle", 64'(rc), 64'd14);

    // EXU stall for 10 cycles, then illegal instruction
    do_reset();
    exu_stall_i = 1'b1;
    nex = 0; nret = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (c >= 3 && state_o == S_EX) nex++;
      if (retire_o) nret++;
    end
    chk("stall ex cycles", 64'(nex), 64'd10);
    chk("stall no retire", 64'(nret), 64'd0);
    @(negedge clk); exu_stall_i = 1'b0; #1;
    chk("stall release ex", 64'(state_o), 64'(S_EX));
    @(negedge clk); #1;
    chk("stall then wb", 64'(state_o), 64'(S_WB));
    chk("stall then retire", 64'(retire_o), 64'h1);
    invalid_inst_i = 1'b1;
    wait_state(S_HALT, 10, "illegal halt");
    chk("illegal cause", 64'(cause_o), 64'(C_ILLEGAL));
    chk("illegal cnt", retire_cnt_o, 64'd1);

    // ebreak wins over illegal
    do_reset();
    ebreak_i = 1'b1; invalid_inst_i = 1'b1;
    wait_state(S_HALT, 10, "ebreak halt");
    chk("ebreak cause", 64'(cause_o), 64'(C_EBREAK));

    // Fetch error: no capture
    do_reset();
    imem_rsp_err = 1'b1;
    wait_state(S_HALT, 10, "ferr halt");
    chk("ferr cause", 64'(cause_o), 64'(C_FETCH_ERR));
    chk("ferr inst", 64'(inst_o), 64'h0);

    // Data error
    do_reset();
    dec_is_mem_i = 1'b1; dmem_rsp_err = 1'b1;
    wait_state(S_HALT, 12, "derr halt");
    chk("derr cause", 64'(cause_o), 64'(C_DATA_ERR));
    chk("derr cnt", retire_cnt_o, 64'd0);

    // Reset in MEM_WAIT, late response dropped
    do_reset();
    dec_is_mem_i = 1'b1; dmem_rsp_valid = 1'b0;
    wait_state(S_MEM_WAIT, 10, "reach mem_wait");
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst state", 64'(state_o), 64'(S_IDLE));
    chk("midrst dvalid", 64'(dmem_req_valid), 64'h0);
    rst = 1'b1; dmem_rsp_valid = 1'b1;
    @(negedge clk); #1;
    chk("midrst c1", 64'(state_o), 64'(S_IF_REQ));
    chk("midrst c1 addr", imem_addr, B);
    dmem_rsp_valid = 1'b0;
    @(negedge clk); #1;
    chk("midrst c2", 64'(state_o), 64'(S_IF_WAIT));
    @(negedge clk); #1;
    chk("midrst c3", 64'(state_o), 64'(S_EX));

    // One addi retires, then imem goes silent: IF_WAIT entered at cycle 6
    do_reset();
    hc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      imem_rsp_valid = (c == 2) || (c >= 26);
      #1;
      if (state_o == S_HALT && hc == 0) hc = c;
    end
    chk("timeout cycle", 64'(hc), 64'd22);
    chk("timeout cause", 64'(cause_o), 64'(C_TIMEOUT));
    chk("timeout sticky", 64'(state_o), 64'(S_HALT));
    chk("timeout ivalid", 64'(imem_req_valid), 64'h0);
    chk("timeout cnt", retire_cnt_o, 64'd1);
    do_reset();
    @(negedge clk); #1;
    chk("restart ivalid", 64'(imem_req_valid), 64'h1);
    chk("restart addr", imem_addr, B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
